// File: rtl/block_reverse_readout_if.sv
// Symbol stream bundle for the block reverse read-out stage.
// The master drives symbols and mode; the slave returns the registered output stream.
interface block_reverse_readout_if #(
  parameter int DATA_W = 1
);
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              mode;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_last;
  logic              primed;

  modport master (
    output in_valid, in_data, mode,
    input  out_valid, out_data, out_last, primed
  );

  modport slave (
    input  in_valid, in_data, mode,
    output out_valid, out_data, out_last, primed
  );
endinterface

// File: rtl/block_reverse_readout.sv
// Buffers symbols in blocks of BLK_LEN and replays each block reversed or in order.
// A single memory is read before it is written at the same address on every accept.
module block_reverse_readout #(
  parameter int DATA_W  = 1,
  parameter int BLK_LEN = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  block_reverse_readout_if.slave bus
);
  localparam int ADDR_W = (BLK_LEN > 1) ? $clog2(BLK_LEN) : 1;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(BLK_LEN - 1);

  typedef enum logic {DIR_UP, DIR_DOWN} dir_t;

  logic [DATA_W-1:0] mem [BLK_LEN];
  logic [ADDR_W-1:0] ptr_reg, ptr_next;
  logic [ADDR_W-1:0] cnt_reg, cnt_next;
  dir_t              dir_reg, dir_next, dir_eff;
  logic              mode_reg, mode_next;
  logic              primed_reg, primed_next;
  logic              out_valid_reg, out_last_reg;
  logic [DATA_W-1:0] out_data_reg;
  logic              accept;
  logic              switch_mode;
  logic [ADDR_W-1:0] addr;

  always_comb begin
    accept      = bus.in_valid;
    switch_mode = accept && (cnt_reg == '0) && (bus.mode != mode_reg);
    // A mode switch restarts the addressing so the new block fills from 0 upward.
    addr        = switch_mode ? '0 : ptr_reg;
    dir_eff     = switch_mode ? DIR_UP : dir_reg;
    cnt_next    = cnt_reg;
    ptr_next    = ptr_reg;
    dir_next    = dir_reg;
    mode_next   = mode_reg;
    primed_next = primed_reg;
    if (accept) begin
      cnt_next = (cnt_reg == LAST) ? '0 : cnt_reg + 1'b1;
      if (switch_mode) begin
        mode_next   = bus.mode;
        primed_next = 1'b0;
      end else if (cnt_reg == LAST) begin
        primed_next = 1'b1;
      end
      ptr_next = addr;
      dir_next = dir_eff;
      if (mode_next) begin
        ptr_next = cnt_next;
        dir_next = DIR_UP;
      end else if (dir_eff == DIR_UP) begin
        if (addr == LAST) dir_next = DIR_DOWN;
        else              ptr_next = addr + 1'b1;
      end else begin
        if (addr == '0) dir_next = DIR_UP;
        else            ptr_next = addr - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_reg       <= '0;
      cnt_reg       <= '0;
      dir_reg       <= DIR_UP;
      mode_reg      <= 1'b0;
      primed_reg    <= 1'b0;
      out_valid_reg <= 1'b0;
      out_last_reg  <= 1'b0;
      out_data_reg  <= '0;
      for (int i = 0; i < BLK_LEN; i++) mem[i] <= '0;
    end else begin
      ptr_reg       <= ptr_next;
      cnt_reg       <= cnt_next;
      dir_reg       <= dir_next;
      mode_reg      <= mode_next;
      primed_reg    <= primed_next;
      out_valid_reg <= accept && primed_reg && !switch_mode;
      // Idle edges leave out_data/out_last untouched.
      if (accept) begin
        out_last_reg <= primed_reg && !switch_mode && (cnt_reg == LAST);
        out_data_reg <= mem[addr];
        mem[addr]    <= bus.in_data;
      end
    end
  end

  assign bus.out_valid = out_valid_reg;
  assign bus.out_data  = out_data_reg;
  assign bus.out_last  = out_last_reg;
  assign bus.primed    = primed_reg;
endmodule

// File: tb/tb_block_reverse_readout.sv
// Self-checking bench: fixed vector tables, hand-written corner sequences and a
// randomized run compared against a block-level reference model.
module tb_block_reverse_readout;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  block_reverse_readout_if #(.DATA_W(8)) bus8 ();
  block_reverse_readout_if #(.DATA_W(1)) bus2 ();

  block_reverse_readout #(.DATA_W(8), .BLK_LEN(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8.slave));
  block_reverse_readout #(.DATA_W(1), .BLK_LEN(2)) dut2 (.clk(clk), .rst(rst), .bus(bus2.slave));

  typedef struct {
    bit         v;
    logic [7:0] d;
    bit         md;
    bit         ev;
    logic [7:0] ed;
    bit         el;
  } vec_t;

  int checks = 0;
  int errors = 0;

  // Reference model: whole previous block kept as an array, replayed by position.
  int         m_pos;
  bit         m_primed, m_mode, m_known, m_last;
  logic [7:0] m_data;
  logic [7:0] m_prev [8];
  logic [7:0] m_cur  [8];
  logic [7:0] got_q  [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_pos = 0; m_primed = 0; m_mode = 0; m_known = 1; m_last = 0; m_data = '0;
  endfunction

  task automatic do_reset();
    bus8.in_valid = 0; bus8.in_data = '0; bus8.mode = 0;
    bus2.in_valid = 0; bus2.in_data = '0; bus2.mode = 0;
    rst = 1;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    model_reset();
    chk("rst_valid8", bus8.out_valid, 0);
    chk("rst_data8", bus8.out_data, 0);
    chk("rst_last8", bus8.out_last, 0);
    chk("rst_primed8", bus8.primed, 0);
    chk("rst_valid2", bus2.out_valid, 0);
  endtask

  task automatic step8(input bit v, input logic [7:0] d, input bit md);
    bit ev;
    logic [7:0] ed;
    bus8.in_valid = v; bus8.in_data = d; bus8.mode = md;
    @(posedge clk);
    #1;
    ev = 0; ed = m_data;
    if (v) begin
      if (m_pos == 0 && md != m_mode) begin
        m_mode = md;
        m_primed = 0;
      end else if (m_primed) begin
        ev = 1;
        ed = m_mode ? m_prev[m_pos] : m_prev[7 - m_pos];
      end
      m_last  = ev && (m_pos == 7);
      m_known = ev;
      if (ev) m_data = ed;
      m_cur[m_pos] = d;
      if (m_pos == 7) begin
        m_prev = m_cur; m_primed = 1; m_pos = 0;
      end else begin
        m_pos++;
      end
    end
    chk("out_valid", bus8.out_valid, ev);
    if (m_known) chk("out_data", bus8.out_data, m_data);
    chk("out_last", bus8.out_last, m_last);
    chk("primed", bus8.primed, m_primed);
    if (bus8.out_valid) begin
      got_q.push_back(bus8.out_data);
      $display("tx in_v=%0d in=%0d mode=%0d -> out=%0d last=%0d", v, d, md, bus8.out_data, bus8.out_last);
    end
  endtask

  vec_t tbl [48];

  initial begin
    bit md_cur;
    int idx, cyc;
    logic [7:0] exp_d;
    bit b2 [6];
    int a2 [6];
    bit o2 [6];
    b2 = '{1, 0, 0, 1, 1, 1};
    a2 = '{0, 1, 1, 0, 0, 1};
    o2 = '{0, 0, 0, 1, 1, 0};

    for (int i = 0; i < 24; i++) begin
      tbl[i] = '{v: 1, d: 8'(i), md: 0, ev: (i >= 8), ed: (i < 16) ? 8'(15 - i) : 8'(31 - i),
                 el: (i == 15 || i == 23)};
      tbl[i + 24] = '{v: 1, d: 8'(i), md: 1, ev: (i >= 8), ed: 8'(i - 8), el: (i == 15 || i == 23)};
    end

    // Continuous reverse then pass streams from the vector table.
    do_reset();
    for (int i = 0; i < 48; i++) begin
      if (i == 24) do_reset();
      step8(tbl[i].v, tbl[i].d, tbl[i].md);
      chk("tbl_valid", bus8.out_valid, tbl[i].ev);
      if (tbl[i].ev) begin
        chk("tbl_data", bus8.out_data, tbl[i].ed);
        chk("tbl_last", bus8.out_last, tbl[i].el);
      end
      if (i == 7) chk("tbl_primed_rise", bus8.primed, 1);
    end

    // Same streams with random idle cycles.
    for (int md = 0; md < 2; md++) begin
      do_reset();
      got_q.delete();
      idx = 0; cyc = 0;
      while (idx < 24 && cyc < 1000) begin
        if ($urandom_range(0, 1) == 1) begin
          step8(1, 8'(idx), md[0]);
          idx++;
        end else begin
          step8(0, 8'($urandom), md[0]);
        end
        cyc++;
      end
      chk("gap_budget", idx, 24);
      chk("gap_count", got_q.size(), 16);
      for (int k = 0; k < 16 && k < got_q.size(); k++) begin
        exp_d = (md == 1) ? 8'(k) : ((k < 8) ? 8'(7 - k) : 8'(23 - k));
        chk("gap_seq", got_q[k], exp_d);
      end
    end

    // Reverse to pass switch raised mid block 3.
    do_reset();
    for (int i = 0; i <= 40; i++) begin
      step8(1, 8'(i), i >= 20);
      if (i == 20) chk("sw_still_rev", bus8.out_data, 11);
      if (i == 24) begin
        chk("sw_suppress", bus8.out_valid, 0);
        chk("sw_primed_drop", bus8.primed, 0);
      end
      if (i == 32) begin
        chk("sw_first_valid", bus8.out_valid, 1);
        chk("sw_first_data", bus8.out_data, 24);
      end
    end

    // Asynchronous reset on the 5th accept of block 2.
    do_reset();
    for (int i = 0; i < 12; i++) step8(1, 8'(i), 0);
    bus8.in_valid = 1; bus8.in_data = 8'd12;
    #2 rst = 1;
    #1;
    chk("arst_valid", bus8.out_valid, 0);
    chk("arst_data", bus8.out_data, 0);
    chk("arst_last", bus8.out_last, 0);
    chk("arst_primed", bus8.primed, 0);
    @(posedge clk);
    #1 rst = 0;
    bus8.in_valid = 0;
    model_reset();
    for (int i = 0; i < 16; i++) begin
      step8(1, 8'(100 + i), 0);
      if (i == 8) chk("arst_reprime", bus8.out_data, 107);
    end

    // Two-symbol blocks of single bits.
    do_reset();
    for (int k = 0; k < 6; k++) begin
      bus2.in_valid = 1; bus2.in_data = b2[k]; bus2.mode = 0;
      #1;
      chk("addr2", 32'(dut2.addr), a2[k]);
      @(posedge clk);
      #1;
      chk("valid2", bus2.out_valid, k >= 2);
      if (k >= 2) begin
        chk("data2", bus2.out_data, o2[k]);
        chk("last2", bus2.out_last, (k == 3 || k == 5));
      end
      $display("tx2 in=%0d -> valid=%0d out=%0d", b2[k], bus2.out_valid, bus2.out_data);
    end
    bus2.in_valid = 0;

    // Randomized data, gaps and mode changes.
    do_reset();
    md_cur = 0;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 39) == 0) md_cur = ~md_cur;
      step8($urandom_range(0, 3) != 0, 8'($urandom), md_cur);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/block_reverse_readout.md
Name: block_reverse_readout

Overview:
- Parametrised successor of the single-bit encoder read-out stage.
- Buffers a stream of DATA_W-bit symbols in blocks of BLK_LEN and emits each block either time-reversed (LIFO per block) or in original order (fixed BLK_LEN-symbol delay).
- Uses one ping-pong-addressed memory with read-before-write.
- Sits between the code generator and the serial output driver. Adds valid qualification, block-last marking and run-time mode selection.

Parameters:
- DATA_W, 1, symbol width in bits (>=1).
- BLK_LEN, 8, symbols per block (>=2).
- ADDR_W, $clog2(BLK_LEN), pointer/counter width. Derived; not overridden.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  symbol accepted on this edge when high.
- in_data  input  DATA_W  input symbol.
- mode  input  1  0 = reverse each block, 1 = pass-through delay. Sampled only at block start.
- out_valid  output  1  out_data/out_last valid this cycle.
- out_data  output  DATA_W  output symbol.
- out_last  output  1  high with the final symbol of an output block.
- primed  output  1  high once one full block is buffered in the active mode.

Behaviour:
- Reset (asynchronous, rst=1): ptr=0, dir=up, cnt=0, active_mode=0, primed=0, memory cleared. Outputs out_valid=0, out_data=0, out_last=0.
- Accept: an edge with in_valid=1. No accept means all state holds, out_valid=0 next cycle, and out_data/out_last hold their last values.
- On each accept, read-before-write at address ptr:
  - out_data <= mem[ptr].
  - out_valid <= primed (value before this edge).
  - out_last <= primed && (cnt==BLK_LEN-1).
  - mem[ptr] <= in_data.
- Latency: out_* registered, valid the cycle after the accept.
- cnt: position in block, increments per accept and wraps BLK_LEN-1 -> 0. primed is set when cnt wraps.
- Block start (accept with cnt==0): mode is sampled.
  - If mode == active_mode, the new block runs in active_mode.
  - If mode differs: active_mode <= mode, primed <= 0 on this same edge, ptr restarts at 0 with dir=up, and this accept's output is suppressed (out_valid=0). The block buffered before the switch is discarded. The first valid output in the new mode follows one full priming block.
- Reverse mode (active_mode=0) pointer update per accept:
  - dir=up, ptr==BLK_LEN-1: ptr holds, dir <= down.
  - dir=down, ptr==0: ptr holds, dir <= up.
  - Otherwise ptr +/- 1 per dir.
  - Resulting address sequence: 0..N-1, N-1..0, 0..N-1, ...
  - Each output block is the previous input block reversed.
- Pass mode (active_mode=1): ptr = cnt (0..BLK_LEN-1 wrapping), dir fixed up. Output equals input delayed by BLK_LEN accepts.
- Invariant: at block start, ptr ∈ {0, BLK_LEN-1}.
- Gaps in in_valid anywhere, including across block boundaries, do not alter ordering.
- Reset mid-block: all progress lost. Re-prime required; no stale data is ever flagged valid.
- No backpressure: the downstream stage must accept every valid output.

Test Plan:
1. Reverse, DATA_W=8, BLK_LEN=8, in_valid continuous, inputs 0..23:
   - No out_valid for inputs 0..7; primed rises after the 8th accept.
   - Outputs for inputs 8..15 = 7,6,...,0, then for 16..23 = 15,...,8.
   - out_last with outputs 0 and 8.
2. Pass mode from reset, inputs 0..23 → outputs 0..15 one cycle after accepts 8..23 (input−8). out_last with 7 and 15.
3. Random in_valid gaps (~50% duty), same streams as 1 and 2:
   - Identical output sequences to the gap-free runs.
   - out_valid low in the cycle after every idle edge; out_data stable across gaps.
4. Mode switch reverse→pass raised mid-block 3, input sequence continuing:
   - Switch takes effect only at the next block start.
   - That block's outputs are suppressed and primed drops.
   - After one priming block, outputs are input−8.
5. Assert rst on the 5th accept of block 2:
   - Outputs go 0 immediately (asynchronous).
   - After release, 8 accepts give no out_valid; then correct reversal of the post-reset block.
6. BLK_LEN=2, DATA_W=1, reverse, bits 1,0,0,1,1,1:
   - Outputs 0,1,1,0 after the first block.
   - Address sequence 0,1,1,0,0,1.
